sepconv_pointwise_tdm: RTL
==========================

// Module: sepconv_pointwise_tdm
// PURPOSE
// - Parametrised, time-multiplexed pointwise (1x1) convolution stage for separable-conv layers: one CIN-channel pixel in, one COUT-channel pixel out.
// - Sits after any depthwise stage; replaces fixed 16->32 pointwise blocks with CIN/COUT/LANES-configurable hardware.
// - Adds loadable weights/bias, ready/valid backpressure and fixed-point saturation.
// PARAMETERS
// - DATA_WIDTH  32  signed fixed-point width of activations, weights, bias
// - FRAC_BITS   16  fractional bits (Q format) of all operands
// - CIN         16  input channels
// - COUT        32  output channels; COUT % LANES == 0 (elaboration error otherwise)
// - LANES        4  output channels computed per cycle; G = COUT/LANES groups
// PORTS
// - clk        in   1                    clock, rising edge
// - rst        in   1                    reset, asynchronous, active-high
// - Data_In    in   DATA_WIDTH*CIN       channel c at [c*DATA_WIDTH +: DATA_WIDTH]
// - Valid_In   in   1                    input pixel valid
// - Ready_Out  out  1                    block can accept a pixel
// - Data_Out   out  DATA_WIDTH*COUT      channel o at [o*DATA_WIDTH +: DATA_WIDTH]
// - Valid_Out  out  1                    output pixel valid
// - Ready_In   in   1                    downstream accepts output
// - Wgt_We     in   1                    weight/bias write strobe
// - Wgt_Addr   in   $clog2(COUT*(CIN+1)) index o*(CIN+1)+c; c==CIN selects bias of channel o
// - Wgt_Data   in   DATA_WIDTH           weight/bias value
// BEHAVIOUR
// - Reset: state IDLE, group counter 0, Data_Out 0, Valid_Out 0, weight/bias file 0; Ready_Out 0 while rst high.
// - FSM IDLE -> COMPUTE -> OUTPUT -> IDLE. Ready_Out = (state==IDLE) & ~rst.
// - IDLE: Valid_In & Ready_Out at edge k captures Data_In, go COMPUTE, g=0.
// - COMPUTE: cycle k+1+g computes channels g*LANES..g*LANES+LANES-1, registered into Data_Out slice at end of that cycle; after g==G-1 -> OUTPUT.
// - OUTPUT: Valid_Out=1 from cycle k+G+1; Data_Out, Valid_Out stable until Valid_Out & Ready_In; then IDLE, Valid_Out 0 next cycle.
// - Throughput: one pixel per G+2 cycles with Ready_In held high; no overlap of input and output.
// - Data_Out slices not yet updated in COMPUTE hold the previous pixel (not observed: Valid_Out low).
// - Arithmetic per channel o: acc = sum_c(x_c*w_oc) + (bias_o <<< FRAC_BITS); products 2*DATA_WIDTH signed, acc has +$clog2(CIN+1) guard bits (no internal overflow).
// - Result = acc >>> FRAC_BITS (arithmetic shift, truncation toward -inf), saturated to [-2^(DW-1), 2^(DW-1)-1].
// - Weight writes: accepted only in IDLE (same-edge write with a pixel capture is accepted; write takes effect for that pixel? no: weights sampled from COMPUTE cycles, so it applies); Wgt_We outside IDLE is dropped; Wgt_Addr >= COUT*(CIN+1) dropped.
// - Valid_In while not IDLE is ignored (not buffered); upstream must hold until Ready_Out.
// - Reset asserted mid-operation: immediate return to reset values incl. weights; in-flight pixel lost.
// CONFIGURATION
// - SEPCONV_RELU_EN defined: after saturation, negative results are replaced with 0 (ReLU fused, no added latency).
// - Not defined: saturated signed result output unchanged.
// STRUCTURE
// - Package sepconv_pkg: FSM state enum (IDLE/COMPUTE/OUTPUT), sat function (acc -> DATA_WIDTH), guard-bit/addr-width localparam helpers.
// - Sub-module sepconv_mac_lane: combinational CIN-input dot product + bias + shift + saturate (+ optional ReLU); LANES instances.
// - Top: FSM, group counter, input capture register, weight/bias register file, lane-to-slice muxing.
// TESTING (DATA_WIDTH=32, FRAC_BITS=16, CIN=16, COUT=32, LANES=4, G=8; 1.0 = 0x00010000)
// - Identity: w[o][c]=1.0 iff c==o%16, bias 0, x_c=c*1.0 -> Data_Out ch o = (o%16)*1.0; Valid_Out 9 cycles after accept edge.
// - Bias/rounding: weights 0, bias 0x00018000 -> all channels 0x00018000; one weight 0x00008000, input 0xFFFFFFFF -> 0xFFFFFFFF (floor).
// - Saturation: all w=x=0x7FFF0000 -> 0x7FFFFFFF; w=0x80000000 -> 0x80000000, or 0x00000000 with SEPCONV_RELU_EN.
// - Backpressure: Ready_In low 5 cycles in OUTPUT -> Data_Out stable, Ready_Out 0, second Valid_In not captured; captured 1 cycle after handshake.
// - Reset mid-COMPUTE (g=3): Valid_Out 0, Data_Out 0, weights 0, Ready_Out 1 first cycle after rst release.
// - Weight write during COMPUTE -> dropped; readback via identity pixel shows old value.

Source files
------------

// File: rtl/sepconv_pkg.sv
// Shared types and helpers for the time-multiplexed pointwise convolution stage.
// SEPCONV_RELU_EN (optional) fuses a ReLU after saturation in every MAC lane.
package sepconv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_e;

  // Working width for saturation; must cover 2*DATA_WIDTH plus guard bits.
  localparam int SAT_W = 128;

  function automatic int guard_bits(input int cin);
    return $clog2(cin + 1);
  endfunction

  function automatic int addr_bits(input int cout, input int cin);
    return $clog2(cout * (cin + 1));
  endfunction

  // Clamp an already-shifted accumulator into a signed dw-bit range.
  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] v,
                                                  input int dw);
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    one = {{(SAT_W-1){1'b0}}, 1'b1};
    hi  = (one <<< (dw - 1)) - one;
    lo  = -(one <<< (dw - 1));
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/sepconv_mac_lane.sv
// One output channel: CIN-term signed dot product plus bias, Q-format rescale and saturation.
// SEPCONV_RELU_EN clamps negative results to zero with no extra latency.
module sepconv_mac_lane
  import sepconv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int CIN        = 16
) (
  input  logic [CIN*DATA_WIDTH-1:0] x_i,
  input  logic [CIN*DATA_WIDTH-1:0] w_i,
  input  logic [DATA_WIDTH-1:0]     bias_i,
  output logic [DATA_WIDTH-1:0]     y_o
);

  localparam int PW    = 2 * DATA_WIDTH;
  localparam int ACC_W = PW + guard_bits(CIN);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] shifted;
  logic signed [PW-1:0]    xe;
  logic signed [PW-1:0]    we;
  logic signed [PW-1:0]    prod;
  logic [DATA_WIDTH-1:0]   res;

  always_comb begin
    // Bias is aligned to the product's 2*FRAC_BITS binary point before summing.
    acc  = {{(ACC_W-DATA_WIDTH){bias_i[DATA_WIDTH-1]}}, bias_i};
    acc  = acc <<< FRAC_BITS;
    xe   = '0;
    we   = '0;
    prod = '0;
    for (int c = 0; c < CIN; c++) begin
      xe   = {{DATA_WIDTH{x_i[c*DATA_WIDTH+DATA_WIDTH-1]}}, x_i[c*DATA_WIDTH +: DATA_WIDTH]};
      we   = {{DATA_WIDTH{w_i[c*DATA_WIDTH+DATA_WIDTH-1]}}, w_i[c*DATA_WIDTH +: DATA_WIDTH]};
      prod = xe * we;
      acc  = acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
    end
    shifted = acc >>> FRAC_BITS;
    res     = DATA_WIDTH'(sat({{(SAT_W-ACC_W){shifted[ACC_W-1]}}, shifted}, DATA_WIDTH));
`ifdef SEPCONV_RELU_EN
    y_o = res[DATA_WIDTH-1] ? '0 : res;
`else
    y_o = res;
`endif
  end

endmodule

// File: rtl/sepconv_pointwise_tdm.sv
// Time-multiplexed 1x1 convolution: LANES output channels per cycle over COUT/LANES groups.
// Optional SEPCONV_RELU_EN enables a fused ReLU in the MAC lanes.
module sepconv_pointwise_tdm
  import sepconv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int CIN        = 16,
  parameter int COUT       = 32,
  parameter int LANES      = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_WIDTH*CIN-1:0]          Data_In,
  input  logic                               Valid_In,
  output logic                               Ready_Out,
  output logic [DATA_WIDTH*COUT-1:0]         Data_Out,
  output logic                               Valid_Out,
  input  logic                               Ready_In,
  input  logic                               Wgt_We,
  input  logic [$clog2(COUT*(CIN+1))-1:0]    Wgt_Addr,
  input  logic [DATA_WIDTH-1:0]              Wgt_Data
);

  localparam int G   = COUT / LANES;
  localparam int G_W = (G > 1) ? $clog2(G) : 1;
  localparam int NW  = COUT * (CIN + 1);
  localparam int AW  = addr_bits(COUT, CIN);
  localparam logic [AW:0] NW_L = (AW+1)'(NW);

  if (COUT % LANES != 0) begin : g_bad_cfg
    $error("sepconv_pointwise_tdm: COUT must be a multiple of LANES");
  end

  state_e                       state_q, state_d;
  logic [G_W-1:0]               g_q, g_d;
  logic [CIN*DATA_WIDTH-1:0]    x_q;
  logic [COUT*DATA_WIDTH-1:0]   dout_q, dout_d;
  logic [DATA_WIDTH-1:0]        wgt_q [NW];
  logic [LANES*DATA_WIDTH-1:0]  lane_y;
  logic                         capture;
  logic                         wgt_wr;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // the input side is ready only in IDLE, and the output holds data/valid until taken.
  assign Ready_Out = (state_q == IDLE) & ~rst;
  assign Valid_Out = (state_q == OUTPUT);
  assign Data_Out  = dout_q;
  assign wgt_wr    = (state_q == IDLE) && Wgt_We && ({1'b0, Wgt_Addr} < NW_L);

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (Valid_In) begin
          state_d = COMPUTE;
          g_d     = '0;
          capture = 1'b1;
        end
      end
      COMPUTE: begin
        if (g_q == G_W'(G - 1)) state_d = OUTPUT;
        else g_d = g_q + 1'b1;
      end
      OUTPUT: begin
        if (Ready_In) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dout_d = dout_q;
    if (state_q == COMPUTE) begin
      for (int gi = 0; gi < G; gi++) begin
        if (g_q == G_W'(gi)) begin
          for (int l = 0; l < LANES; l++) begin
            dout_d[(gi*LANES+l)*DATA_WIDTH +: DATA_WIDTH] = lane_y[l*DATA_WIDTH +: DATA_WIDTH];
          end
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [CIN*DATA_WIDTH-1:0] w_row;
    logic [DATA_WIDTH-1:0]     b_val;
    logic [DATA_WIDTH-1:0]     y_val;
    logic [AW-1:0]             base;

    // Each lane reads the weight row of channel g*LANES+l for the active group.
    always_comb begin
      base  = AW'((int'(g_q) * LANES + l) * (CIN + 1));
      w_row = '0;
      for (int c = 0; c < CIN; c++) begin
        w_row[c*DATA_WIDTH +: DATA_WIDTH] = wgt_q[base + AW'(c)];
      end
      b_val = wgt_q[base + AW'(CIN)];
    end

    sepconv_mac_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .FRAC_BITS (FRAC_BITS),
      .CIN       (CIN)
    ) u_lane (
      .x_i   (x_q),
      .w_i   (w_row),
      .bias_i(b_val),
      .y_o   (y_val)
    );

    assign lane_y[l*DATA_WIDTH +: DATA_WIDTH] = y_val;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      g_q     <= '0;
      x_q     <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      dout_q  <= dout_d;
      if (capture) x_q <= Data_In;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NW; i++) wgt_q[i] <= '0;
    end else if (wgt_wr) begin
      wgt_q[Wgt_Addr] <= Wgt_Data;
    end
  end

endmodule
